// File: rtl/shift_left_64.sv
// Constant logical left shift of a 64-bit operand: combinational result plus a
// registered copy. Build with SHIFT_LEFT_64_STATUS_EN to add the carry_out/zero status flops.
module shift_left_64 #(
  parameter int unsigned SHIFT_AMT = 1  // legal range 1..63
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] in,
  input  logic        in_valid,
  output logic [63:0] out,
  output logic [63:0] out_q,
  output logic        out_valid,
  output logic        carry_out,
  output logic        zero
);

  // Handshake: valid-only, no ready. Each rising edge with in_valid=1 captures
  // `out` into out_q and raises out_valid for exactly the following cycle;
  // with in_valid=0 out_q holds and out_valid drops. No stalls, no backpressure.

  // Bits shifted past bit 63 are discarded and the vacated LSBs fill with 0.
  assign out = in << SHIFT_AMT;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_q <= out;
      end
    end
  end

`ifdef SHIFT_LEFT_64_STATUS_EN
  logic shifted_off;

  assign shifted_off = |in[63 -: SHIFT_AMT];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      carry_out <= 1'b0;
      zero      <= 1'b0;
    end else if (in_valid) begin
      carry_out <= shifted_off;
      zero      <= (out == 64'd0);
    end
  end
`else
  assign carry_out = 1'b0;
  assign zero      = 1'b0;
`endif

endmodule

// File: tb/tb_shift_left_64.sv
// Directed bench for shift_left_64 (SHIFT_AMT=1): combinational result, capture
// latency, hold, back-to-back streaming and asynchronous reset behaviour.
module tb_shift_left_64;

  logic        clk;
  logic        reset_n;
  logic [63:0] in;
  logic        in_valid;
  logic [63:0] out;
  logic [63:0] out_q;
  logic        out_valid;
  logic        carry_out;
  logic        zero;

  int vectors = 0;
  int miscompares = 0;

`ifdef SHIFT_LEFT_64_STATUS_EN
  localparam bit status_on = 1'b1;
`else
  localparam bit status_on = 1'b0;
`endif

  shift_left_64 #(.SHIFT_AMT(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in        (in),
    .in_valid  (in_valid),
    .out       (out),
    .out_q     (out_q),
    .out_valid (out_valid),
    .carry_out (carry_out),
    .zero      (zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_regs(input string tag, input logic [63:0] exp_q, input logic exp_valid,
                            input logic exp_carry, input logic exp_zero);
    check({tag, ".out_q"}, out_q, exp_q);
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_valid});
    check({tag, ".carry_out"}, {63'd0, carry_out}, {63'd0, exp_carry & status_on});
    check({tag, ".zero"}, {63'd0, zero}, {63'd0, exp_zero & status_on});
  endtask

  // drive at the falling edge, then let one rising edge go by and sample at the next falling edge
  task automatic step(input logic [63:0] value, input logic valid);
    in       = value;
    in_valid = valid;
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    in       = 64'h0000_0000_0000_0001;
    in_valid = 1'b1;

    // reset holds registers at zero across clock edges; out still tracks in
    repeat (2) @(negedge clk);
    check_regs("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    check("reset_comb", out, 64'h0000_0000_0000_0002);

    // first capture after reset release
    reset_n = 1'b1;
    step(64'h0000_0000_0000_0001, 1'b1);
    check_regs("one", 64'h0000_0000_0000_0002, 1'b1, 1'b0, 1'b0);

    // top bit shifted off: result zero, carry set
    in = 64'h8000_0000_0000_0000;
    #1 check("msb_comb", out, 64'h0000_0000_0000_0000);
    @(negedge clk);
    check_regs("msb", 64'd0, 1'b1, 1'b1, 1'b1);

    in = 64'h7FFF_FFFF_FFFF_FFFF;
    #1 check("max_pos_comb", out, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    check_regs("max_pos", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0);

    in = 64'h1234_5678_9ABC_DEF0;
    #1 check("pattern_comb", out, 64'h2468_ACF1_3579_BDE0);
    @(negedge clk);
    check_regs("pattern", 64'h2468_ACF1_3579_BDE0, 1'b1, 1'b0, 1'b0);

    // zero input, then one idle cycle: out_q and flags hold, out_valid drops
    step(64'd0, 1'b1);
    check_regs("zero_in", 64'd0, 1'b1, 1'b0, 1'b1);
    step(64'h0000_0000_0000_0005, 1'b0);
    check_regs("idle", 64'd0, 1'b0, 1'b0, 1'b1);
    check("idle_comb", out, 64'h0000_0000_0000_000A);

    // three back-to-back captures
    step(64'h0000_0000_0000_0003, 1'b1);
    check_regs("b2b_0", 64'h0000_0000_0000_0006, 1'b1, 1'b0, 1'b0);
    step(64'hFFFF_0000_0000_0001, 1'b1);
    check_regs("b2b_1", 64'hFFFE_0000_0000_0002, 1'b1, 1'b1, 1'b0);
    step(64'h4000_0000_0000_0000, 1'b1);
    check_regs("b2b_2", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0);

    // mid-stream asynchronous reset between clock edges
    step(64'h8000_0000_0000_0011, 1'b1);
    check_regs("pre_rst", 64'h0000_0000_0000_0022, 1'b1, 1'b1, 1'b0);
    #2 reset_n = 1'b0;
    #1 check_regs("async_rst", 64'd0, 1'b0, 1'b0, 1'b0);
    check("async_rst_comb", out, 64'h0000_0000_0000_0022);
    in = 64'h0000_0000_0000_0100;
    #1 check("rst_track_comb", out, 64'h0000_0000_0000_0200);
    @(negedge clk);
    check_regs("rst_held", 64'd0, 1'b0, 1'b0, 1'b0);

    // release with in_valid low: nothing captured until a valid edge
    reset_n = 1'b1;
    step(64'h0000_0000_0000_0100, 1'b0);
    check_regs("post_rst_idle", 64'd0, 1'b0, 1'b0, 1'b0);
    step(64'hC000_0000_0000_0000, 1'b1);
    check_regs("post_rst_cap", 64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0);
    step(64'd0, 1'b0);
    check_regs("final_idle", 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_left_64.md
SHIFT_LEFT_64 -- requirements
Module: shift_left_64

Interface
REQ-001 Parameter SHIFT_AMT, default 1: constant left-shift distance, legal range 1..63.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous and active-low.
REQ-004 in  input  64  operand.
REQ-005 out  output  64  combinational result, in << SHIFT_AMT.
REQ-006 in_valid  input  1  qualifies `in` for the registered path.
REQ-007 out_q  output  64  registered copy of `out`.
REQ-008 out_valid  output  1  marks `out_q` as holding a fresh result.
REQ-009 carry_out  output  1  registered OR of the bits shifted off the top (macro-dependent, REQ-025).
REQ-010 zero  output  1  registered flag, out_q == 0 (macro-dependent, REQ-025).

Function
REQ-011 `out` SHALL be in[63-SHIFT_AMT:0] followed by SHIFT_AMT zero LSBs, with no clock dependence.
- `out` is a pure function of `in`.
- It is independent of `clk`, `reset_n` and `in_valid`.
REQ-012 Bits shifted beyond bit 63 SHALL be discarded; there is no wrap-around or rotation.
REQ-013 Logical shift only: the vacated LSBs SHALL be 0 and the sign is not preserved.
REQ-014 At a rising edge with in_valid=1, `out_q` SHALL load `out` and `out_valid` SHALL be 1 in the next cycle.
- Latency is exactly 1 cycle.
REQ-015 At a rising edge with in_valid=0, `out_q` SHALL hold its value and `out_valid` SHALL go to 0.
REQ-016 Back-to-back in_valid=1 cycles SHALL produce one out_q result per cycle with no bubbles or stalls.
- There is no backpressure input.
REQ-017 `carry_out` SHALL load (|in[63:64-SHIFT_AMT]) under the same condition as `out_q` (REQ-014).
REQ-018 `zero` SHALL load (out == 0) under the same condition as `out_q` (REQ-014).
REQ-019 Input 0 SHALL yield `out` = 0; input 64'h8000000000000000 with SHIFT_AMT=1 SHALL yield `out` = 0 and carry 1.

Reset
REQ-020 While reset_n=0, out_q, out_valid, carry_out and zero SHALL be held at 0 regardless of `clk`.
REQ-021 Reset assertion SHALL clear the registers immediately, without waiting for a clock edge.
REQ-022 Reset deassertion is synchronized externally; the first capture SHALL be at the first rising edge with reset_n=1 and in_valid=1.
REQ-023 `out` SHALL remain combinationally valid during reset.
REQ-024 Reset asserted mid-stream SHALL drop any in-flight result; out_valid SHALL read 0 until a new capture.

Configuration
REQ-025 Macro SHIFT_LEFT_64_STATUS_EN selects whether the status registers exist.
- Defined: the carry_out and zero registers SHALL exist and behave per REQ-017, REQ-018 and REQ-020.
- Undefined: carry_out and zero SHALL be tied to constant 0, with no flops inferred.
- All other behaviour is identical in both builds.

Verification
REQ-026 in=64'h0000000000000001 -> out=64'h0000000000000002 in the same cycle; after one in_valid edge, out_q=64'h0000000000000002, out_valid=1.
REQ-027 in=64'h8000000000000000 -> out=64'h0000000000000000; after capture, zero=1 and carry_out=1 (macro on); both flags 0 with macro off.
REQ-028 in=64'h7FFFFFFFFFFFFFFF -> out=64'hFFFFFFFFFFFFFFFE, carry_out=0; in=64'h123456789ABCDEF0 -> out=64'h2468ACF13579BDE0.
REQ-029 in=0 -> out=0, zero=1 after capture; then in_valid low for one cycle -> out_valid=0 and out_q holds 0.
REQ-030 Three back-to-back valid inputs -> three consecutive out_valid=1 cycles with matching out_q values.
- Assert reset_n=0 between clock edges -> all registered outputs 0 immediately while `out` still tracks `in`.
